arb_requester: RTL
==================

// Module: arb_requester
// PURPOSE
//  Requester-side agent for the two-way request/grant arbiter: buffers jobs, drives one
//  request line, waits for grant, then streams a burst on the shared bus while granted.
//  One instance per requester; its req/gnt pair connects to an arbiter Rn/Gn pair.
//  Handles grant loss mid-burst (resume) and grant starvation (timeout, back off, retry).
// PARAMETERS
//  DATA_W    8   width of job_data / bus_data
//  LEN_W     4   width of job_len; burst = job_len+1 beats (1..2**LEN_W)
//  DEPTH     4   job FIFO entries (power of 2, >=2)
//  TIMEOUT   16  cycles in REQUEST without gnt before back-off (>=2)
// PORTS
//  clock        in   1       rising-edge clock
//  reset        in   1       synchronous, active-high
//  job_valid    in   1       job offered
//  job_ready    out  1       FIFO can accept (= !full)
//  job_data     in   DATA_W  base data word of job
//  job_len      in   LEN_W   beats-1
//  req          out  1       request to arbiter
//  gnt          in   1       grant from arbiter
//  bus_valid    out  1       beat presented on bus
//  bus_data     out  DATA_W  job_data + beat_idx (mod 2**DATA_W)
//  bus_last     out  1       final beat of burst
//  timeout_err  out  1       one-cycle pulse on starvation back-off
//  pending      out  $clog2(DEPTH)+1  jobs queued (incl. one in flight)
// BEHAVIOUR
//  Reset: state IDLE, FIFO flushed, beat_idx=0, timer=0; req, bus_valid, bus_last,
//   timeout_err, pending = 0; job_ready=1. Reset asserted mid-burst aborts immediately.
//  Push on edge with job_valid&&job_ready; pop on edge that transfers the last beat.
//   Push+pop same edge: pending unchanged. job_ready=0 when full; job_valid ignored.
//  All outputs decoded from registered state/counters (no comb path from gnt to outputs).
//  FSM states IDLE, REQUEST, XFER, BACKOFF:
//   IDLE:    pending!=0 -> REQUEST (timer=0). req=0.
//   REQUEST: req=1. gnt=1 -> XFER. gnt=0: timer++; timer==TIMEOUT-1 -> BACKOFF,
//            timeout_err=1 for the following cycle.
//   XFER:    req=1, bus_valid=1, bus_data=head.data+beat_idx, bus_last=(beat_idx==head.len).
//            Beat transferred on edge with gnt=1: beat_idx++; if last -> pop, beat_idx=0,
//            BACKOFF. gnt=0 on edge -> REQUEST, beat_idx held (resume, no repeat), timer=0.
//   BACKOFF: req=0 for exactly one cycle so arbiter sees request drop -> IDLE.
//  Latency: job pushed at edge k -> req high after edge k+1 (from empty, idle).
//   gnt sampled high at edge g -> first beat valid after g; N-beat burst uninterrupted
//   occupies N cycles, req low one cycle after last beat.
//  Back-to-back jobs always separated by BACKOFF+IDLE (req low >=1 cycle).
//  Burst of 1 (job_len=0): single XFER cycle with bus_last=1.
//  bus_data wraps modulo 2**DATA_W; beat_idx is LEN_W bits, never exceeds head.len.
//  gnt while in IDLE/BACKOFF ignored.
// STRUCTURE
//  Shared package arb_pkg: state encodings (IDLE/REQUEST/XFER/BACKOFF), job struct
//   {data,len} width macros; reused by arbiter and its benches.
//  One sub-module: arb_job_fifo (sync FIFO, DEPTH x (DATA_W+LEN_W), show-ahead head,
//   full/empty/count). FSM, beat counter, timeout timer in top.
// TESTING
//  1 Single job data=8'h10 len=2, gnt tied high -> req after 2 edges; bus_data 10,11,12,
//    bus_last on 12; req low next cycle; pending 1->0.
//  2 Push 5 jobs with DEPTH=4 -> 4 accepted, job_ready=0 after 4th, 5th held; pending=4.
//  3 Grant dropped after beat 1 of len=3 job base 8'hFE -> REQUEST, req stays 1; regrant
//    -> beats resume FF,00 (wrap), 01; no beat repeated.
//  4 gnt held low 16 cycles -> timeout_err single pulse, req low 1 cycle, re-requests,
//    job not lost; later grant completes burst.
//  5 Reset asserted mid-burst -> next cycle all outputs 0, pending 0, job_ready 1; gnt
//    afterwards produces no bus_valid.
//  6 Two queued jobs, gnt high throughout -> req low exactly 1 cycle between bursts,
//    bus_last once per job.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the request/grant arbiter family: requester FSM
// encodings, default widths and the job record.
package arb_pkg;

  localparam int ARB_DATA_W  = 8;
  localparam int ARB_LEN_W   = 4;
  localparam int ARB_DEPTH   = 4;
  localparam int ARB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    XFER    = 2'd2,
    BACKOFF = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [ARB_DATA_W-1:0] data;
    logic [ARB_LEN_W-1:0]  len;
  } arb_job_t;

endpackage

// File: rtl/arb_job_fifo.sv
// Synchronous job FIFO with show-ahead head: the oldest entry is always visible
// on head_data/head_len while the FIFO is non-empty.
module arb_job_fifo
  import arb_pkg::*;
#(
  parameter int DATA_W = ARB_DATA_W,
  parameter int LEN_W  = ARB_LEN_W,
  parameter int DEPTH  = ARB_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic [LEN_W-1:0]           push_len,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head_data,
  output logic [LEN_W-1:0]           head_len,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [LEN_W-1:0]  len_mem  [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  // Requests that would overflow or underflow are dropped here.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      data_mem[wptr] <= push_data;
      len_mem[wptr]  <= push_len;
    end
  end

  always_comb begin
    head_data = data_mem[rptr];
    head_len  = len_mem[rptr];
    full      = (count == FULL_COUNT);
    empty     = (count == '0);
  end

endmodule

// File: rtl/arb_requester.sv
// Requester-side agent: queues jobs, requests the shared bus, streams a burst
// while granted, resumes after grant loss and backs off when starved.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DATA_W  = ARB_DATA_W,
  parameter int LEN_W   = ARB_LEN_W,
  parameter int DEPTH   = ARB_DEPTH,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [DATA_W-1:0]          job_data,
  input  logic [LEN_W-1:0]           job_len,
  output logic                       req,
  input  logic                       gnt,
  output logic                       bus_valid,
  output logic [DATA_W-1:0]          bus_data,
  output logic                       bus_last,
  output logic                       timeout_err,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int TIMER_W = $clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  arb_state_e         state;
  arb_state_e         state_n;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_n;
  logic [LEN_W-1:0]   beat_idx;
  logic [LEN_W-1:0]   beat_n;
  logic               toerr_q;
  logic               toerr_n;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W-1:0]  head_data;
  logic [LEN_W-1:0]   head_len;
  logic [$clog2(DEPTH):0] fifo_count;
  logic               head_is_last;

  assign fifo_push    = job_valid && !fifo_full;
  assign head_is_last = (beat_idx == head_len);

  arb_job_fifo #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (job_data),
    .push_len  (job_len),
    .pop       (fifo_pop),
    .head_data (head_data),
    .head_len  (head_len),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      beat_idx <= '0;
      toerr_q  <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      beat_idx <= beat_n;
      toerr_q  <= toerr_n;
    end
  end

  // BACKOFF makes IDLE's decision in the same cycle, so req drops for exactly
  // one cycle between bursts and after a starvation timeout.
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    beat_n   = beat_idx;
    toerr_n  = 1'b0;
    fifo_pop = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_n = REQUEST;
          timer_n = '0;
        end
      end
      REQUEST: begin
        if (gnt) begin
          state_n = XFER;
        end else if (timer == TIMER_LAST) begin
          state_n = BACKOFF;
          timer_n = '0;
          toerr_n = 1'b1;
        end else begin
          timer_n = timer + TIMER_W'(1);
        end
      end
      XFER: begin
        if (gnt) begin
          if (head_is_last) begin
            fifo_pop = 1'b1;
            beat_n   = '0;
            state_n  = BACKOFF;
          end else begin
            beat_n = beat_idx + LEN_W'(1);
          end
        end else begin
          state_n = REQUEST;
          timer_n = '0;
        end
      end
      BACKOFF: begin
        if (!fifo_empty) begin
          state_n = REQUEST;
          timer_n = '0;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs depend only on registered state and the FIFO head, never on gnt.
  always_comb begin
    req         = (state == REQUEST) || (state == XFER);
    bus_valid   = (state == XFER);
    bus_data    = '0;
    bus_last    = 1'b0;
    if (state == XFER) begin
      bus_data = head_data + DATA_W'(beat_idx);
      bus_last = head_is_last;
    end
    timeout_err = toerr_q;
    pending     = fifo_count;
    job_ready   = !fifo_full;
  end

endmodule
